// File: rtl/filtc_core.sv
// rtl/filtc_core.sv - FILTC stage: APP = AP + floor((AX*512 - AP) / 16), registered.
module filtc_core (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       AX,
    input  logic [9:0] AP,
    output logic [9:0] APP,
    output logic       out_valid
);

    logic [6:0] dif_hi;
    logic [9:0] difsx;
    logic [9:0] app_next;

    // DIF >> 4 is formed directly: the low nibble of AP only contributes a borrow,
    // which gives the floor rounding for negative differences.
    assign dif_hi   = {1'b0, AX, 5'b0} - {1'b0, AP[9:4]} - {6'b0, |AP[3:0]};
    assign difsx    = {{3{dif_hi[6]}}, dif_hi};
    assign app_next = difsx + AP;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            APP       <= 10'd0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                APP <= app_next;
            end
        end
    end

endmodule

// File: tb/tb_filtc_core.sv
// tb/tb_filtc_core.sv - randomized and directed check of filtc_core against an arithmetic model.
module tb_filtc_core;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       AX = 1'b0;
    logic [9:0] AP = 10'd0;
    logic [9:0] APP;
    logic       out_valid;

    int n_cmp = 0;
    int n_bad = 0;

    int exp_app = 0;
    bit exp_valid = 1'b0;

    filtc_core dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .AX       (AX),
        .AP       (AP),
        .APP      (APP),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic int model_app(input int ax, input int ap);
        int d;
        int q;
        d = ax * 512 - ap;
        q = d >>> 4;
        return (ap + q) & 1023;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_app   <= 0;
            exp_valid <= 1'b0;
        end else begin
            exp_valid <= in_valid;
            if (in_valid) exp_app <= model_app(int'(AX), int'(AP));
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_app", int'(APP), exp_app);
        check("model_valid", int'(out_valid), int'(exp_valid));
    end

    task automatic drive(input bit v, input bit ax, input int ap);
        @(posedge clk);
        #2;
        in_valid = v;
        AX = ax;
        AP = 10'(ap);
    endtask

    task automatic apply_check(input string name, input bit ax, input int ap, input int req);
        drive(1'b1, ax, ap);
        @(posedge clk);
        @(negedge clk);
        check(name, int'(APP), req);
        check({name, "_valid"}, int'(out_valid), 1);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b1;
        AX = 1'b1;
        AP = 10'd512;
        repeat (3) begin
            @(negedge clk);
            check("reset_app", int'(APP), 0);
            check("reset_valid", int'(out_valid), 0);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("release_app", int'(APP), 512);
        check("release_valid", int'(out_valid), 1);

        apply_check("ax0_ap0", 1'b0, 0, 0);
        apply_check("ax1_ap0", 1'b1, 0, 32);
        apply_check("ax0_ap512", 1'b0, 512, 480);
        apply_check("ax1_ap512", 1'b1, 512, 512);
        apply_check("ax0_ap1023", 1'b0, 1023, 959);
        apply_check("ax1_ap1023", 1'b1, 1023, 991);
        apply_check("ax0_ap15", 1'b0, 15, 14);
        apply_check("ax0_ap1", 1'b0, 1, 0);

        apply_check("hold_pre", 1'b1, 0, 32);
        drive(1'b0, 1'b0, 700);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_app", int'(APP), 32);
            check("hold_valid", int'(out_valid), 0);
        end

        drive(1'b1, 1'b1, 0);
        @(posedge clk);
        #1 AP = 10'd300;
        #2 reset = 1'b1;
        #0.5;
        check("async_rst_app", int'(APP), 0);
        check("async_rst_valid", int'(out_valid), 0);
        #0.5 reset = 1'b0;
        AX = 1'b0;
        AP = 10'd512;
        @(posedge clk);
        @(negedge clk);
        check("recover_app", int'(APP), 480);
        check("recover_valid", int'(out_valid), 1);

        for (int i = 0; i < 1000; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)));
        end
        for (int i = 0; i < 2048; i++) begin
            drive(1'b1, 1'(i / 1024), i % 1024);
        end
        drive(1'b0, 1'b0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/filtc_core.md
# filtc_core

Registered FILTC stage of the ADPCM adaptive-predictor speed-control path. Each accepted sample low-pass filters the 10-bit speed-control parameter AP toward the target set by the 1-bit flag AX. The filter gain is 2^-4. The result APP is registered for the next stage.

## Interface
Parameters: none (all widths fixed).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  AX/AP valid this cycle; sample accepted on rising clk edge
- AX  input  1  speed-control target flag (0 → target 0, 1 → target 512)
- AP  input  10  current speed-control parameter, unsigned 0..1023
- APP  output  10  filtered parameter, registered
- out_valid  output  1  APP updated from the sample accepted on the previous edge

## Operation
- DIF (11 bits, two's complement) = ((AX << 9) + 2048 − AP) mod 2048, i.e. (AX·512 − AP) wrapped to 11 bits.
- DIFS = DIF[10] (sign bit).
- DIFSX (10 bits):
  - DIFS = 0: DIFSX = DIF >> 4.
  - DIFS = 1: DIFSX = (DIF >> 4) + 896. This is a 4-bit arithmetic shift right, sign-extended into bits 9:7.
- APP_next = (DIFSX + AP) mod 1024. Carries beyond bit 9 are discarded.
- Negative DIF rounds toward −∞ (floor). Examples: AP=15, AX=0 gives 14; AP=1, AX=0 gives 0.
- Fixed points: AX=0, AP=0 holds at 0; AX=1, AP=512 holds at 512.
- No saturation and no other state; the datapath is purely the arithmetic above.

## Timing
- Asynchronous reset: while reset=1, APP=0 and out_valid=0 immediately, independent of clk.
- Release of reset is synchronous in effect. The first capture occurs on the first rising clk edge with reset=0.
- Latency is 1 cycle.
- On a rising edge with in_valid=1:
  - APP ← APP_next computed from AX/AP present at that edge.
  - out_valid ← 1.
- On a rising edge with in_valid=0: APP holds its previous value; out_valid ← 0.
- Back-to-back samples are accepted every cycle, giving a throughput of 1 sample/cycle. There is no backpressure.
- Reset asserted mid-stream:
  - Any sample present at an edge during reset is discarded.
  - APP=0 and out_valid=0 persist until the first in_valid=1 edge after release.
- AX/AP are sampled only at the clock edge. Changes between edges have no effect on outputs.

## Test plan
- Reset: assert reset with in_valid=1, AX=1, AP=512 across edges → APP=0, out_valid=0 throughout; deassert → APP=512 one edge later.
- Basic values, one sample per cycle (APP one cycle after each):
  - AX=0, AP=0 → 0
  - AX=1, AP=0 → 32
  - AX=0, AP=512 → 480
  - AX=1, AP=512 → 512
- Wrap/sign boundaries:
  - AX=0, AP=1023 → 959
  - AX=1, AP=1023 → 991
  - AX=0, AP=15 → 14
  - AX=0, AP=1 → 0
- Hold: in_valid=1 with AX=1, AP=0 (APP=32), then in_valid=0 with AP=700 for 3 cycles → APP stays 32, out_valid=0.
- Mid-stream reset: stream in_valid=1, pulse reset asynchronously between edges → APP and out_valid go to 0 before the next edge; recovery on the first valid edge after release.
- Random sweep: 1000 random AX/AP with random in_valid → APP matches the DIF/DIFSX formula from the previous accepted sample, with a 1-cycle lag; exhaustive 2×1024 sweep passes.
